// File: rtl/spike_aer_encoder.sv
// AER encoder: turns per-neuron spike pulses into {addr, ts} events
// and buffers them in a first-word-fall-through FIFO.
//
// Ports:
//   clk, reset_n   clock, async active-low reset
//   enable         advance timestamp and capture spikes
//   spike_in       one pulse bit per neuron
//   aer_valid/aer_ready/aer_addr/aer_ts   event stream (head of FIFO)
//   fifo_count     occupied FIFO entries
//   overflow       sticky loss flag
//   drop_count     saturating count of lost events
//   clear_ovf      synchronous clear of overflow and drop_count
module spike_aer_encoder #(
  parameter int N_NEURON   = 8,
  parameter int ADDR_W     = 3,
  parameter int TS_W       = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic [N_NEURON-1:0]          spike_in,
  output logic                         aer_valid,
  input  logic                         aer_ready,
  output logic [ADDR_W-1:0]            aer_addr,
  output logic [TS_W-1:0]              aer_ts,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         overflow,
  output logic [15:0]                  drop_count,
  input  logic                         clear_ovf
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = $clog2(N_NEURON + 2);
  localparam int EW = ADDR_W + TS_W;

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  state_t              state, state_n;
  logic [TS_W-1:0]     ts;
  logic [N_NEURON-1:0] scan_mask, scan_mask_n;
  logic [TS_W-1:0]     scan_ts, scan_ts_n;
  logic [N_NEURON-1:0] pend_mask, pend_mask_n;
  logic [TS_W-1:0]     pend_ts, pend_ts_n;

  logic [N_NEURON-1:0] new_sp;
  logic [N_NEURON-1:0] low_oh;
  logic [N_NEURON-1:0] scan_rem;
  logic [N_NEURON-1:0] pend_or;
  logic [N_NEURON-1:0] coll;
  logic [ADDR_W-1:0]   low_idx;
  logic                push;

  logic [EW-1:0]       mem [FIFO_DEPTH];
  logic [PW-1:0]       wptr, rptr;
  logic [EW-1:0]       head;
  logic [ADDR_W-1:0]   last_addr;
  logic [TS_W-1:0]     last_ts;
  logic                full;
  logic                do_push, do_pop;
  logic                full_drop;

  logic [IW-1:0]       coll_cnt;
  logic [IW-1:0]       drop_inc;
  logic [16:0]         drop_sum;

  assign new_sp   = enable ? spike_in : '0;
  // Isolate the lowest set bit; clearing it advances the scan.
  assign low_oh   = scan_mask & (~scan_mask + N_NEURON'(1));
  assign scan_rem = scan_mask & ~low_oh;

  always_comb begin
    low_idx = '0;
    for (int i = N_NEURON - 1; i >= 0; i--) begin
      if (scan_mask[i]) low_idx = ADDR_W'(i);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts <= '0;
    end else if (enable) begin
      ts <= ts + TS_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      scan_mask <= '0;
      scan_ts   <= '0;
      pend_mask <= '0;
      pend_ts   <= '0;
    end else begin
      state     <= state_n;
      scan_mask <= scan_mask_n;
      scan_ts   <= scan_ts_n;
      pend_mask <= pend_mask_n;
      pend_ts   <= pend_ts_n;
    end
  end

  always_comb begin
    state_n     = state;
    scan_mask_n = scan_mask;
    scan_ts_n   = scan_ts;
    pend_mask_n = pend_mask;
    pend_ts_n   = pend_ts;
    pend_or     = pend_mask | new_sp;
    coll        = '0;
    push        = 1'b0;
    unique case (state)
      IDLE: begin
        if (|new_sp) begin
          scan_mask_n = new_sp;
          scan_ts_n   = ts;
          state_n     = SCAN;
        end
      end
      SCAN: begin
        push = 1'b1;
        coll = pend_mask & new_sp;
        // First spike into an empty pending frame stamps it.
        if (pend_mask == '0 && new_sp != '0) begin
          pend_ts_n = ts;
        end
        if (scan_rem == '0) begin
          pend_mask_n = '0;
          if (pend_or != '0) begin
            scan_mask_n = pend_or;
            scan_ts_n   = pend_ts_n;
          end else begin
            scan_mask_n = '0;
            state_n     = IDLE;
          end
        end else begin
          scan_mask_n = scan_rem;
          pend_mask_n = pend_or;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Fullness is judged before any same-cycle pop.
  assign full      = fifo_count == CW'(FIFO_DEPTH);
  assign aer_valid = fifo_count != '0;
  assign do_push   = push & ~full;
  assign full_drop = push & full;
  assign do_pop    = aer_valid & aer_ready;
  assign head      = mem[rptr];

  // When empty, the last popped event stays on the bus.
  assign aer_addr = aer_valid ? head[EW-1:TS_W] : last_addr;
  assign aer_ts   = aer_valid ? head[TS_W-1:0]  : last_ts;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= {low_idx, scan_ts};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
      last_addr  <= '0;
      last_ts    <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop) begin
        rptr      <= rptr + PW'(1);
        last_addr <= head[EW-1:TS_W];
        last_ts   <= head[TS_W-1:0];
      end
      unique case ({do_push, do_pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_comb begin
    coll_cnt = '0;
    for (int i = 0; i < N_NEURON; i++) begin
      coll_cnt = coll_cnt + IW'(coll[i]);
    end
  end

  assign drop_inc = coll_cnt + IW'(full_drop);
  assign drop_sum = {1'b0, drop_count} + 17'(drop_inc);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clear_ovf) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop_inc != '0) begin
      overflow   <= 1'b1;
      drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Scoreboard bench for spike_aer_encoder.
// Directed stimulus; a negedge monitor pops expected events.
module tb_spike_aer_encoder;

  typedef struct packed {
    logic [2:0]  addr;
    logic [15:0] ts;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  spike_in = '0;
  logic        aer_valid;
  logic        aer_ready = 1'b0;
  logic [2:0]  aer_addr;
  logic [15:0] aer_ts;
  logic [4:0]  fifo_count;
  logic        overflow;
  logic [15:0] drop_count;
  logic        clear_ovf = 1'b0;

  int          errors = 0;
  int          checks = 0;
  ev_t         exp_q[$];
  ev_t         mon_e;
  logic [15:0] mts;
  logic [15:0] t0;
  logic [7:0]  m;

  spike_aer_encoder #(
    .N_NEURON  (8),
    .ADDR_W    (3),
    .TS_W      (16),
    .FIFO_DEPTH(16)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .spike_in  (spike_in),
    .aer_valid (aer_valid),
    .aer_ready (aer_ready),
    .aer_addr  (aer_addr),
    .aer_ts    (aer_ts),
    .fifo_count(fifo_count),
    .overflow  (overflow),
    .drop_count(drop_count),
    .clear_ovf (clear_ovf)
  );

  always #5 clk = ~clk;

  // Reference timestamp: counts enabled edges since reset.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) mts <= '0;
    else if (enable) mts <= mts + 16'd1;
  end

  always @(negedge clk) begin
    if (reset_n && aer_valid && aer_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got addr=%0d ts=%0h, required none",
                 aer_addr, aer_ts);
      end else begin
        mon_e = exp_q.pop_front();
        if (aer_addr !== mon_e.addr || aer_ts !== mon_e.ts) begin
          errors++;
          $display("FAIL event: got addr=%0d ts=%0h, required addr=%0d ts=%0h",
                   aer_addr, aer_ts, mon_e.addr, mon_e.ts);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic expect_ev(input logic [2:0] a, input logic [15:0] t);
    ev_t e;
    e.addr = a;
    e.ts   = t;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    enable    = 1'b0;
    spike_in  = '0;
    aer_ready = 1'b0;
    clear_ovf = 1'b0;
    exp_q.delete();
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic wait_ts(input logic [15:0] t, input int lim);
    int n = 0;
    while (mts !== t && n < lim) begin
      tick();
      n++;
    end
    if (mts !== t) begin
      checks++;
      errors++;
      $display("FAIL wait_ts: got ts=%0h, required %0h", mts, t);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending events, required 0",
               exp_q.size());
    end
    tick();
    chk("drain_count", 32'(fifo_count), 32'd0);
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_valid", 32'(aer_valid), 32'd0);
    chk("rst_addr", 32'(aer_addr), 32'd0);
    chk("rst_ts", 32'(aer_ts), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);

    // 1: single spike, addr 5 at ts 3, one-cycle latency
    do_reset();
    enable    = 1'b1;
    aer_ready = 1'b1;
    wait_ts(16'd3, 20);
    expect_ev(3'd5, 16'd3);
    spike_in = 8'h20;
    tick();
    spike_in = 8'h00;
    chk("t1_valid_k", 32'(aer_valid), 32'd0);
    tick();
    chk("t1_valid_k1", 32'(aer_valid), 32'd1);
    wait_drain();

    // 2: three-bit frame in ascending order, shared ts
    t0 = mts;
    expect_ev(3'd0, t0);
    expect_ev(3'd4, t0);
    expect_ev(3'd7, t0);
    spike_in = 8'b1001_0001;
    tick();
    spike_in = 8'h00;
    wait_drain();

    // 3: collision in pending frame, no bubble after frame
    do_reset();
    enable    = 1'b1;
    aer_ready = 1'b1;
    wait_ts(16'd8, 20);
    for (int i = 0; i < 8; i++) expect_ev(3'(i), 16'd8);
    expect_ev(3'd2, 16'd10);
    spike_in = 8'hFF;
    tick();
    spike_in = 8'h00;
    tick();
    for (int k = 10; k <= 18; k++) begin
      chk($sformatf("t3_valid_%0d", k), 32'(aer_valid), 32'd1);
      spike_in = (k == 10 || k == 11) ? 8'h04 : 8'h00;
      tick();
    end
    spike_in = 8'h00;
    chk("t3_valid_end", 32'(aer_valid), 32'd0);
    chk("t3_drop", 32'(drop_count), 32'd1);
    wait_drain();

    // 4: fill FIFO, one full-drop, drain in order, clear
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) expect_ev(3'(i % 8), 16'(2 * i));
      m = 8'h01 << (i % 8);
      spike_in = m;
      tick();
      spike_in = 8'h00;
      tick();
    end
    chk("t4_count", 32'(fifo_count), 32'd16);
    chk("t4_ovf", 32'(overflow), 32'd1);
    chk("t4_drop", 32'(drop_count), 32'd1);
    chk("t4_hold_addr", 32'(aer_addr), 32'd0);
    chk("t4_hold_ts", 32'(aer_ts), 32'd0);
    tick();
    chk("t4_stable_ts", 32'(aer_ts), 32'd0);
    aer_ready = 1'b1;
    wait_drain();
    chk("t4_last_addr", 32'(aer_addr), 32'd7);
    chk("t4_last_ts", 32'(aer_ts), 32'd30);
    chk("t4_ovf_sticky", 32'(overflow), 32'd1);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    chk("t4_clr_ovf", 32'(overflow), 32'd0);
    chk("t4_clr_drop", 32'(drop_count), 32'd0);

    // 5: timestamp wrap across back-to-back captures
    do_reset();
    enable    = 1'b1;
    aer_ready = 1'b1;
    wait_ts(16'hFFFE, 70000);
    expect_ev(3'd0, 16'hFFFE);
    expect_ev(3'd1, 16'hFFFF);
    expect_ev(3'd2, 16'h0000);
    spike_in = 8'h01;
    tick();
    spike_in = 8'h02;
    tick();
    spike_in = 8'h04;
    tick();
    spike_in = 8'h00;
    wait_drain();

    // 6: reset mid-scan discards queued events
    do_reset();
    enable = 1'b1;
    spike_in = 8'hFF;
    tick();
    spike_in = 8'h00;
    repeat (5) tick();
    chk("t6_count5", 32'(fifo_count), 32'd5);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(aer_valid), 32'd0);
    chk("t6_rst_count", 32'(fifo_count), 32'd0);
    tick();
    tick();
    reset_n   = 1'b1;
    aer_ready = 1'b1;
    repeat (20) tick();
    chk("t6_post_count", 32'(fifo_count), 32'd0);
    chk("t6_post_valid", 32'(aer_valid), 32'd0);
    chk("t6_post_drop", 32'(drop_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
